// File: rtl/lcd_bus_responder.sv
// HD44780-style character LCD model on the far end of the 8-bit LCD bus.
// Decodes instruction and data cycles, models the busy flag, address counter and the 2x40 DDRAM.
module lcd_bus_responder #(
  parameter int BUSY_CYCLES = 1850,
  parameter int BUSY_LONG   = 76000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       lcd_e,
  input  logic       lcd_rw,
  input  logic       lcd_rs,
  output logic [7:0] data_out,
  output logic       data_oe,
  output logic       busy,
  output logic [6:0] ac,
  output logic       disp_on,
  output logic       cursor_on,
  output logic       blink_on,
  output logic       err_busy,
  input  logic [6:0] rd_addr,
  output logic [7:0] rd_data,
  output logic [1:0] fsm_state,
  output logic       entry_shift
);

  localparam int CW = $clog2(BUSY_LONG + 1);

  typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_CLEAR, ST_BUSY} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [6:0]    clr_idx;
  logic          id;
  logic          rd_pend;
  logic [7:0]    mem [0:79];

  logic [10:0] sync1, sync2;
  logic        e_d;
  logic        e_s, rs_s, rw_s;
  logic [7:0]  data_s;
  logic        rise, fall;

  // Bus cycle: a write is committed on the E fall; a read drives data from the
  // E rise until the E fall. rs/rw/data are sampled alongside the synchronized E.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= '0;
      sync2 <= '0;
      e_d   <= 1'b0;
    end else begin
      sync1 <= {lcd_e, lcd_rs, lcd_rw, data_in};
      sync2 <= sync1;
      e_d   <= sync2[10];
    end
  end

  assign e_s    = sync2[10];
  assign rs_s   = sync2[9];
  assign rw_s   = sync2[8];
  assign data_s = sync2[7:0];
  assign rise   = e_s & ~e_d;
  assign fall   = ~e_s & e_d;

  logic [6:0] ac_inc, ac_dec, ac_next, ac_idx, rd_idx;
  logic       rd_ok;

  always_comb begin
    ac_inc  = (ac == 7'h27) ? 7'h40 : (ac == 7'h67) ? 7'h00 : ac + 7'd1;
    ac_dec  = (ac == 7'h00) ? 7'h67 : (ac == 7'h40) ? 7'h27 : ac - 7'd1;
    ac_next = id ? ac_inc : ac_dec;
    ac_idx  = ac[6] ? 7'd40 + {1'b0, ac[5:0]} : {1'b0, ac[5:0]};
    rd_idx  = rd_addr[6] ? 7'd40 + {1'b0, rd_addr[5:0]} : {1'b0, rd_addr[5:0]};
    rd_ok   = rd_addr[5:0] < 6'd40;
  end

  logic       mem_we;
  logic [6:0] mem_addr;
  logic [7:0] mem_wdata;

  always_comb begin
    mem_we    = (state == ST_CLEAR) || (state == ST_IDLE && fall && !rw_s && rs_s);
    mem_addr  = (state == ST_CLEAR) ? clr_idx : ac_idx;
    mem_wdata = (state == ST_CLEAR) ? 8'h20 : data_s;
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rd_data <= 8'h00;
    else        rd_data <= rd_ok ? mem[rd_idx] : 8'h00;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_INIT;
      cnt         <= '0;
      clr_idx     <= '0;
      id          <= 1'b1;
      entry_shift <= 1'b0;
      rd_pend     <= 1'b0;
      data_out    <= 8'h00;
      data_oe     <= 1'b0;
      busy        <= 1'b0;
      ac          <= 7'h00;
      disp_on     <= 1'b0;
      cursor_on   <= 1'b0;
      blink_on    <= 1'b0;
      err_busy    <= 1'b0;
    end else begin
      err_busy <= 1'b0;
      if (rise && rw_s) begin
        data_oe <= 1'b1;
        if (!rs_s) begin
          data_out <= {busy, ac};
        end else if (state == ST_IDLE) begin
          data_out <= mem[ac_idx];
          rd_pend  <= 1'b1;
        end else begin
          data_out <= 8'h00;
          if (busy) err_busy <= 1'b1;
        end
      end
      if (fall) begin
        data_oe <= 1'b0;
        rd_pend <= 1'b0;
      end
      if (busy && fall && !rw_s) err_busy <= 1'b1;

      case (state)
        ST_INIT: begin
          state   <= ST_CLEAR;
          busy    <= 1'b1;
          cnt     <= CW'(BUSY_LONG - 1);
          clr_idx <= '0;
        end
        ST_CLEAR: begin
          clr_idx <= clr_idx + 7'd1;
          // The walk is charged against the long busy time, so it may expire on the last entry.
          if (clr_idx == 7'd79) begin
            ac <= 7'h00;
            id <= 1'b1;
            if (cnt == '0) begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end else begin
              state <= ST_BUSY;
              cnt   <= cnt - CW'(1);
            end
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        ST_BUSY: begin
          if (cnt == '0) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        ST_IDLE: begin
          if (fall && !rw_s) begin
            state <= ST_BUSY;
            busy  <= 1'b1;
            cnt   <= CW'(BUSY_CYCLES - 1);
            if (rs_s) begin
              ac <= ac_next;
            end else begin
              casez (data_s)
                8'b1???????: ac <= (data_s[5:0] >= 6'd40) ? {data_s[6], 6'd0} : data_s[6:0];
                8'b0001????: if (!data_s[3]) ac <= data_s[2] ? ac_inc : ac_dec;
                8'b00001???: begin
                  disp_on   <= data_s[2];
                  cursor_on <= data_s[1];
                  blink_on  <= data_s[0];
                end
                8'b000001??: begin
                  id          <= data_s[1];
                  entry_shift <= data_s[0];
                end
                8'b0000001?: begin
                  ac  <= 7'h00;
                  cnt <= CW'(BUSY_LONG - 1);
                end
                8'b00000001: begin
                  state   <= ST_CLEAR;
                  clr_idx <= '0;
                  cnt     <= CW'(BUSY_LONG - 1);
                end
                default: ;
              endcase
            end
          end else if (fall && rw_s && rs_s && rd_pend) begin
            ac    <= ac_next;
            state <= ST_BUSY;
            busy  <= 1'b1;
            cnt   <= CW'(BUSY_CYCLES - 1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign fsm_state = state;

endmodule
